updown_mod_counter: RTL and testbench

Parametrised synchronous up/down counter with a run-time modulus, parallel load, synchronous clear and a selectable wrap or saturate mode. It replaces the fixed 4-bit ripple T-flip-flop counters in general control logic. All flops are clocked on the posedge of one clock, so there is no ripple skew between bits. Its tc output is combinational carry/borrow, so instances cascade into wider counters.

---
 rtl/updown_mod_counter_if.sv | 53 +++++
 rtl/updown_mod_counter.sv | 99 +++++++++
 tb/tb_updown_mod_counter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/updown_mod_counter_if.sv
// ---------------------------------------------------------------------------
// updown_mod_counter_if
//   Control and status bundle for updown_mod_counter.
//
//   Handshake: there is no valid/ready pair. Every control input is sampled
//   on each rising clock edge, and each status output is valid while its
//   inputs are steady: count and ovf are registered, while at_max, at_zero
//   and tc are combinational.
//
//   Signals:
//     clr      - synchronous clear to 0 (highest priority)
//     load     - synchronous parallel load of min(load_val, max_val)
//     load_val - value to load
//     en       - count enable
//     up       - direction, 1 = increment, 0 = decrement
//     sat      - 1 = saturate at the ends, 0 = wrap
//     max_val  - terminal value, legal range is 0..max_val
//     count    - current count (registered)
//     at_max   - count == max_val
//     at_zero  - count == 0
//     tc       - carry/borrow for cascading
//     ovf      - one-cycle pulse following a wrap
//
//   Modports:
//     master - drives the controls and observes the status
//     slave  - the counter itself
// ---------------------------------------------------------------------------
interface updown_mod_counter_if #(
   parameter int WIDTH = 4
);
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             en;
   logic             up;
   logic             sat;
   logic [WIDTH-1:0] max_val;
   logic [WIDTH-1:0] count;
   logic             at_max;
   logic             at_zero;
   logic             tc;
   logic             ovf;

   modport master (
      output clr, load, load_val, en, up, sat, max_val,
      input  count, at_max, at_zero, tc, ovf
   );

   modport slave (
      input  clr, load, load_val, en, up, sat, max_val,
      output count, at_max, at_zero, tc, ovf
   );
endinterface

// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// updown_mod_counter
//   Synchronous up/down counter with a run-time modulus (0..max_val),
//   parallel load, synchronous clear and a wrap or saturate mode.
//   Every flop is clocked on the same posedge, so there is no ripple skew.
//   Because tc is combinational carry/borrow, the tc output of one stage can
//   drive the en input of the next stage to build wider counters.
//
//   Parameters:
//     WIDTH   - counter width in bits (>= 1)
//     RST_VAL - count value while reset is held (must be <= every max_val)
//
//   Ports:
//     clk - clock, rising edge active
//     rst - reset, asynchronous, active-low
//     bus - updown_mod_counter_if.slave (controls in, status out)
//
//   Edge priority: clr > load > en > hold.
// ---------------------------------------------------------------------------
module updown_mod_counter #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   updown_mod_counter_if.slave   bus
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_q;
   logic             ovf_q;
   logic [WIDTH-1:0] next_count;
   logic             next_ovf;
   logic             at_max;
   logic             at_zero;
   logic             in_range;

   assign at_max   = (count_q == bus.max_val);
   assign at_zero  = (count_q == '0);
   assign in_range = (count_q <= bus.max_val);

   // Next-state logic. next_ovf marks a wrap: up past the top (including
   // from out of range) onto 0, or down from 0 onto max_val. An
   // out-of-range count that is pulled back down onto max_val is a
   // correction, not a wrap, so it leaves ovf low.
   always_comb begin
      next_count = count_q;
      next_ovf   = 1'b0;
      if (bus.clr) begin
         next_count = '0;
      end else if (bus.load) begin
         next_count = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
      end else if (bus.en) begin
         if (!in_range) begin
            // max_val was lowered below the current count
            if (bus.up && !bus.sat) begin
               next_count = '0;
               next_ovf   = 1'b1;
            end else begin
               next_count = bus.max_val;
            end
         end else if (bus.up) begin
            if (!at_max) begin
               next_count = count_q + ONE;
            end else if (!bus.sat) begin
               next_count = '0;
               next_ovf   = 1'b1;
            end
         end else begin
            if (!at_zero) begin
               next_count = count_q - ONE;
            end else if (!bus.sat) begin
               next_count = bus.max_val;
               next_ovf   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= RST_VAL;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= next_count;
         ovf_q   <= next_ovf;
      end
   end

   assign bus.count   = count_q;
   assign bus.ovf     = ovf_q;
   assign bus.at_max  = at_max;
   assign bus.at_zero = at_zero;
   // tc is not gated by clr, load or sat, so a cascade sees the true
   // terminal condition of this stage.
   assign bus.tc      = bus.en & ((bus.up & at_max) | (~bus.up & at_zero));

endmodule

// File: tb/tb_updown_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_mod_counter
//   Self-checking bench for updown_mod_counter: a vector table, hand-written
//   corner sequences, randomized stimulus against a reference model, and a
//   two-stage cascade.
// ---------------------------------------------------------------------------
module tb_updown_mod_counter;

   localparam int W = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   updown_mod_counter_if #(.WIDTH(W)) bus ();
   updown_mod_counter #(.WIDTH(W), .RST_VAL(4'd0)) dut (.clk(clk), .rst(rst), .bus(bus));

   updown_mod_counter_if #(.WIDTH(W)) lo_bus ();
   updown_mod_counter_if #(.WIDTH(W)) hi_bus ();
   updown_mod_counter #(.WIDTH(W), .RST_VAL(4'd0)) dut_lo (.clk(clk), .rst(rst), .bus(lo_bus));
   updown_mod_counter #(.WIDTH(W), .RST_VAL(4'd0)) dut_hi (.clk(clk), .rst(rst), .bus(hi_bus));
   assign hi_bus.en = lo_bus.tc;

   // ---------------- scoreboard ----------------
   int n_pass  = 0;
   int n_total = 0;
   logic [W:0] exp_q[$];   // {ovf, count} expected after the next edge
   int   m_count = 0;      // reference model state

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Reference model: the counter's rules as plain integer arithmetic.
   function automatic void model_next(input int cur, input bit c, input bit l,
                                      input int lv, input bit e, input bit u,
                                      input bit s, input int mx,
                                      output int nxt, output bit novf);
      nxt  = cur;
      novf = 0;
      if (c)           nxt = 0;
      else if (l)      nxt = (lv < mx) ? lv : mx;
      else if (!e)     nxt = cur;
      else if (u) begin
         if (cur < mx) nxt = cur + 1;
         else if (s)   nxt = mx;
         else begin nxt = 0; novf = 1; end
      end else begin
         if (cur > mx)      nxt = mx;
         else if (cur > 0)  nxt = cur - 1;
         else if (s)        nxt = 0;
         else begin nxt = mx; novf = (mx >= 0); end
      end
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input bit c, input bit l, input int lv, input bit e,
                        input bit u, input bit s, input int mx);
      bus.clr      = c;
      bus.load     = l;
      bus.load_val = W'(lv);
      bus.en       = e;
      bus.up       = u;
      bus.sat      = s;
      bus.max_val  = W'(mx);
   endtask

   // Drive one cycle, check combinational status against the model, clock,
   // then check registered outputs against the scoreboard.
   task automatic apply(input string tag, input bit c, input bit l, input int lv,
                        input bit e, input bit u, input bit s, input int mx);
      int  nxt;
      bit  novf;
      logic [W:0] exp;
      drive(c, l, lv, e, u, s, mx);
      #1;
      check({tag, ".tc"}, int'(bus.tc),
            int'(e && ((u && m_count == mx) || (!u && m_count == 0))));
      check({tag, ".at_max"},  int'(bus.at_max),  int'(m_count == mx));
      check({tag, ".at_zero"}, int'(bus.at_zero), int'(m_count == 0));
      model_next(m_count, c, l, lv, e, u, s, mx, nxt, novf);
      exp_q.push_back({novf, W'(nxt)});
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check({tag, ".count"}, int'(bus.count), int'(exp[W-1:0]));
      check({tag, ".ovf"},   int'(bus.ovf),   int'(exp[W]));
      m_count = nxt;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       clr;
      logic       load;
      logic [3:0] lv;
      logic       en;
      logic       up;
      logic       sat;
      logic [3:0] mx;
      logic       exp_tc;     // before the edge
      logic [3:0] exp_count;  // after the edge
      logic       exp_ovf;    // after the edge
   } vec_t;

   vec_t vecs[20];

   initial begin
      int ovf_seen;
      int c_mx;

      bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.en = 1'b0;
      bus.up = 1'b1; bus.sat = 1'b0; bus.max_val = 4'd15;
      lo_bus.clr = 1'b1; lo_bus.load = 1'b0; lo_bus.load_val = '0; lo_bus.en = 1'b0;
      lo_bus.up = 1'b1; lo_bus.sat = 1'b0; lo_bus.max_val = 4'd15;
      hi_bus.clr = 1'b1; hi_bus.load = 1'b0; hi_bus.load_val = '0;
      hi_bus.up = 1'b1; hi_bus.sat = 1'b0; hi_bus.max_val = 4'd15;

      //            clr   load  lv     en    up    sat   mx     tc    count  ovf
      vecs[0]  = '{1'b0, 1'b1, 4'd5,  1'b1, 1'b1, 1'b0, 4'd9,  1'b0, 4'd5,  1'b0};
      vecs[1]  = '{1'b0, 1'b1, 4'd12, 1'b1, 1'b1, 1'b0, 4'd9,  1'b0, 4'd9,  1'b0};
      vecs[2]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd9,  1'b1, 4'd0,  1'b1};
      vecs[3]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd9,  1'b1, 4'd9,  1'b1};
      vecs[4]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd9,  1'b1, 4'd9,  1'b0};
      vecs[5]  = '{1'b1, 1'b1, 4'd3,  1'b1, 1'b1, 1'b1, 4'd9,  1'b1, 4'd0,  1'b0};
      vecs[6]  = '{1'b0, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 4'd12, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd7,  1'b0, 4'd0,  1'b1};
      vecs[8]  = '{1'b0, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 4'd12, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd7,  1'b0, 4'd7,  1'b0};
      vecs[10] = '{1'b0, 1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 4'd12, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd7,  1'b0, 4'd7,  1'b0};
      vecs[12] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd7,  1'b0, 4'd7,  1'b0};
      vecs[13] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd7,  1'b0, 4'd6,  1'b0};
      vecs[14] = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0};
      vecs[15] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0,  1'b1};
      vecs[16] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd0,  1'b1};
      vecs[17] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd0,  1'b1, 4'd0,  1'b0};
      vecs[18] = '{1'b0, 1'b1, 4'd15, 1'b1, 1'b1, 1'b0, 4'd15, 1'b0, 4'd15, 1'b0};
      vecs[19] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd15, 1'b1, 4'd0,  1'b1};

      // ---------------- reset state ----------------
      #2;
      check("reset.count",   int'(bus.count),   0);
      check("reset.ovf",     int'(bus.ovf),     0);
      check("reset.at_zero", int'(bus.at_zero), 1);
      @(posedge clk);
      #2;
      rst = 1'b1;

      // ---------------- table ----------------
      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].clr, vecs[i].load, int'(vecs[i].lv), vecs[i].en,
               vecs[i].up, vecs[i].sat, int'(vecs[i].mx));
         #1;
         check($sformatf("vec%0d.tc", i), int'(bus.tc), int'(vecs[i].exp_tc));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d.count", i), int'(bus.count), int'(vecs[i].exp_count));
         check($sformatf("vec%0d.ovf", i),   int'(bus.ovf),   int'(vecs[i].exp_ovf));
         m_count = int'(vecs[i].exp_count);
      end

      // ---------------- full-range count down from 0 ----------------
      apply("down.clr", 1, 0, 0, 0, 0, 0, 15);
      ovf_seen = 0;
      for (int i = 0; i < 32; i++) begin
         apply($sformatf("down%0d", i), 0, 0, 0, 1, 0, 0, 15);
         if (bus.ovf) ovf_seen++;
      end
      check("down.ovf_pulses", ovf_seen, 2);

      // ---------------- mod-10 up, then saturate ----------------
      apply("mod10.clr", 1, 0, 0, 0, 1, 0, 9);
      for (int i = 0; i < 10; i++) apply($sformatf("mod10_%0d", i), 0, 0, 0, 1, 1, 0, 9);
      check("mod10.at_top", int'(bus.count), 0);
      check("mod10.wrap_ovf", int'(bus.ovf), 1);
      apply("mod10.step", 0, 0, 0, 1, 1, 0, 9);
      check("mod10.ovf_one_cycle", int'(bus.ovf), 0);
      for (int i = 0; i < 12; i++) apply($sformatf("sat%0d", i), 0, 0, 0, 1, 1, 1, 9);
      check("sat.stuck", int'(bus.count), 9);

      // ---------------- async reset mid-cycle ----------------
      apply("rst.clr", 1, 0, 0, 0, 0, 0, 6);
      apply("rst.wrap", 0, 0, 0, 1, 0, 0, 6);   // 0 -> 6 with ovf
      drive(0, 0, 0, 1, 1, 0, 6);
      #3;
      rst = 1'b0;
      #1;
      check("rst.async_count", int'(bus.count), 0);
      check("rst.async_ovf",   int'(bus.ovf),   0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      m_count = 0;
      apply("rst.resume", 0, 0, 0, 1, 1, 0, 6);
      check("rst.resume_val", int'(bus.count), 1);

      // ---------------- randomized against the model ----------------
      c_mx = 15;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) c_mx = $urandom_range(0, 15);
         apply("rand",
               $urandom_range(0, 19) == 0,
               $urandom_range(0, 9) == 0,
               $urandom_range(0, 15),
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) == 0,
               c_mx);
      end

      // ---------------- cascade of two stages ----------------
      lo_bus.clr = 1'b0;
      hi_bus.clr = 1'b0;
      lo_bus.en  = 1'b1;
      repeat (255) @(posedge clk);
      #1;
      check("casc.255", int'({hi_bus.count, lo_bus.count}), 8'hFF);
      check("casc.255_hi_ovf", int'(hi_bus.ovf), 0);
      @(posedge clk);
      #1;
      check("casc.256", int'({hi_bus.count, lo_bus.count}), 0);
      check("casc.256_hi_ovf", int'(hi_bus.ovf), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
